md_sched: RTL and testbench

//  Multi-cycle multiply/divide scheduler and HI/LO owner for the E stage. Accepts one

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_arith.sv | 49 ++++
 rtl/md_sched.sv | 109 ++++++++++
 tb/tb_md_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared HI/LO op encodings, default mult/div latencies and busy-counter width.
package md_pkg;

  typedef enum logic [3:0] {
    HILO_NONE  = 4'd0,
    HILO_MULT  = 4'd1,
    HILO_MULTU = 4'd2,
    HILO_DIV   = 4'd3,
    HILO_DIVU  = 4'd4,
    HILO_MTHI  = 4'd5,
    HILO_MTLO  = 4'd6,
    HILO_MFHI  = 4'd7,
    HILO_MFLO  = 4'd8
  } hilo_op_e;

  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;
  localparam int MD_CNT_W    = 8;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == HILO_MULT) || (op == HILO_MULTU) || (op == HILO_DIV) || (op == HILO_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply / divide producing a {hi,lo} result and a divide-by-zero flag.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_zero_o
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] b_safe, mag_a, mag_b, q_u, r_u, q_m, r_m;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Divisor forced to 1 on zero so no undefined divide is ever evaluated.
  assign b_safe = (b_i == 32'd0) ? 32'd1 : b_i;
  assign mag_a  = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign mag_b  = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
  assign q_u    = a_i / b_safe;
  assign r_u    = a_i % b_safe;
  assign q_m    = mag_a / mag_b;
  assign r_m    = mag_a % mag_b;

  always_comb begin
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (op_i)
      HILO_MULT:  {res_hi_o, res_lo_o} = prod_s;
      HILO_MULTU: {res_hi_o, res_lo_o} = prod_u;
      HILO_DIV: begin
        // Sign-magnitude divide: quotient truncates toward zero, remainder follows dividend.
        res_lo_o = (a_i[31] ^ b_i[31]) ? (~q_m + 32'd1) : q_m;
        res_hi_o = a_i[31] ? (~r_m + 32'd1) : r_m;
      end
      HILO_DIVU: begin
        res_lo_o = q_u;
        res_hi_o = r_u;
      end
      default: ;
    endcase
  end

  assign div_zero_o = (b_i == 32'd0) && ((op_i == HILO_DIV) || (op_i == HILO_DIVU));

endmodule

// File: rtl/md_sched.sv
// E-stage mult/div scheduler and HI/LO owner; busy for the op latency, then commits HI/LO.
// Optional MD_CANCEL_EN adds a cancel port that aborts an in-flight op.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT  = MD_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  hilo_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_d,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_LAT);
  localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_LAT);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         hi_q, hi_d, lo_q, lo_d;
  logic [31:0]         pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic                pend_dz_q, pend_dz_d;
  logic [31:0]         res_hi, res_lo;
  logic                res_dz, is_mult, cancel_hit;

  md_arith u_arith (
    .op_i       (hilo_op),
    .a_i        (src_a),
    .b_i        (src_b),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo),
    .div_zero_o (res_dz)
  );

  assign busy    = (cnt_q != '0);
  assign is_mult = (hilo_op == HILO_MULT) || (hilo_op == HILO_MULTU);

`ifdef MD_CANCEL_EN
  assign cancel_hit = cancel & busy;
`else
  assign cancel_hit = 1'b0;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    if (busy) begin
      // While busy, new starts and MT writes are dropped; hazard logic keeps them away.
      cnt_d = cnt_q - 1'b1;
      if (cancel_hit) begin
        cnt_d     = '0;
        pend_hi_d = 32'd0;
        pend_lo_d = 32'd0;
        pend_dz_d = 1'b0;
      end else if (cnt_q == MD_CNT_W'(1) && !pend_dz_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else begin
      if (start && is_md_op(hilo_op)) begin
        pend_hi_d = res_hi;
        pend_lo_d = res_lo;
        pend_dz_d = res_dz;
        cnt_d     = is_mult ? MULT_CNT : DIV_CNT;
      end
      if (hilo_op == HILO_MTHI) hi_d = src_a;
      if (hilo_op == HILO_MTLO) lo_d = src_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall_md = md_use_d & (busy | start);
  assign md_rdata = (hilo_op == HILO_MFHI) ? hi_q :
                    (hilo_op == HILO_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: expected {hi,lo} pushed when an op starts, popped at commit.
module tb_md_sched;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, md_use_d;
  logic [3:0]  hilo_op;
  logic [31:0] src_a, src_b;
`ifdef MD_CANCEL_EN
  logic        cancel;
`endif
  logic        busy, stall_md;
  logic [31:0] hi, lo, md_rdata;

  int checks = 0;
  int passed = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  md_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .hilo_op  (hilo_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .md_use_d (md_use_d),
`ifdef MD_CANCEL_EN
    .cancel   (cancel),
`endif
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_hilo(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
      chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input logic use_d, input string tag);
    int n;
    exp_q.push_back({eh, el});
    hilo_op = op; src_a = a; src_b = b; start = 1'b1; md_use_d = use_d;
    #1;
    chk({tag, "_stall_start"}, {63'd0, stall_md}, {63'd0, use_d});
    tick();
    start = 1'b0; hilo_op = HILO_NONE;
    n = 0;
    while (busy && n < 40) begin
      chk({tag, "_stall_busy"}, {63'd0, stall_md}, {63'd0, use_d});
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(lat));
    #1;
    chk({tag, "_stall_after"}, {63'd0, stall_md}, 64'd0);
    pop_hilo(tag);
    md_use_d = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; md_use_d = 1'b0; hilo_op = HILO_NONE;
    src_a = 32'd0; src_b = 32'd0;
`ifdef MD_CANCEL_EN
    cancel = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    hilo_op = HILO_MFHI; md_use_d = 1'b1;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, stall_md}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_rdata", {32'd0, md_rdata}, 64'd0);
    hilo_op = HILO_NONE; md_use_d = 1'b0;

    do_op(HILO_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, 1'b0, "mult_neg");
    do_op(HILO_MULT, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 5, 1'b1, "mult_stall");
    hilo_op = HILO_MFLO; #1;
    chk("mflo_rdata", {32'd0, md_rdata}, {32'd0, 32'hFFFF_FFD6});
    hilo_op = HILO_MFHI; #1;
    chk("mfhi_rdata", {32'd0, md_rdata}, {32'd0, 32'hFFFF_FFFF});
    hilo_op = HILO_NONE; #1;
    chk("none_rdata", {32'd0, md_rdata}, 64'd0);
    do_op(HILO_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5, 1'b0, "multu");

    do_op(HILO_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0, "divu");
    do_op(HILO_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, "div_neg_a");
    do_op(HILO_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 1'b1, "div_neg_b");
    do_op(HILO_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0, "div_ovf");

    // Start with a non-mult/div op must not launch anything.
    start = 1'b1; hilo_op = HILO_NONE; src_a = 32'd9; src_b = 32'd9;
    tick();
    chk("start_nonmd_busy", {63'd0, busy}, 64'd0);
    start = 1'b0;

    // MTHI and a second start arrive while a MULT is in flight: both dropped.
    exp_q.push_back({32'd0, 32'd6});
    hilo_op = HILO_MULT; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; hilo_op = HILO_NONE;
    tick();
    hilo_op = HILO_MTHI; src_a = 32'h1234;
    tick();
    hilo_op = HILO_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; hilo_op = HILO_NONE;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk("busy_ignore_cycles", 64'(n), 64'd2);
    pop_hilo("busy_ignore");

    hilo_op = HILO_MTHI; src_a = 32'h1234;
    tick();
    chk("mthi_idle", {32'd0, hi}, {32'd0, 32'h1234});
    hilo_op = HILO_MTHI; src_a = 32'hAA;
    tick();
    hilo_op = HILO_MTLO; src_a = 32'hBB;
    tick();
    hilo_op = HILO_NONE;
    chk("mt_hi", {32'd0, hi}, {32'd0, 32'hAA});
    chk("mt_lo", {32'd0, lo}, {32'd0, 32'hBB});

    do_op(HILO_DIV, 32'd5, 32'd0, 32'hAA, 32'hBB, 10, 1'b0, "div_zero");

`ifdef MD_CANCEL_EN
    hilo_op = HILO_MULT; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; hilo_op = HILO_NONE;
    tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    chk("cancel_hi", {32'd0, hi}, {32'd0, 32'hAA});
    chk("cancel_lo", {32'd0, lo}, {32'd0, 32'hBB});
    for (int i = 0; i < 6; i++) tick();
    chk("cancel_hi_late", {32'd0, hi}, {32'd0, 32'hAA});
    chk("cancel_lo_late", {32'd0, lo}, {32'd0, 32'hBB});
`endif

    // Reset in the third busy cycle drops the op and clears HI/LO.
    hilo_op = HILO_DIVU; src_a = 32'd50; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; hilo_op = HILO_NONE;
    tick(); tick();
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("midrst_lo_late", {32'd0, lo}, 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
